// File: rtl/seq_disp_pkg.sv
// Shared definitions for the sequential-lights display controller.
// Segment bit indices, direction/mode enums, pos width helper and the
// (digit, segment) -> perimeter index map.
package seq_disp_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    typedef enum logic {
        CW  = 1'b0,
        CCW = 1'b1
    } dir_e;

    typedef enum logic {
        CHASE = 1'b0,
        FILL  = 1'b1
    } mode_e;

    // Width of pos: must hold 0..P where P = 2n+4
    function automatic int unsigned pos_w(input int unsigned n);
        return $clog2(2 * n + 5);
    endfunction

    // Perimeter index of a segment on a digit (digit 0 = rightmost), -1 if unused
    function automatic int perim_idx(input int dig, input int seg, input int n);
        int r;
        r = -1;
        case (seg)
            SEG_A: r = n - 1 - dig;
            SEG_B: r = (dig == 0) ? n : -1;
            SEG_C: r = (dig == 0) ? n + 1 : -1;
            SEG_D: r = n + 2 + dig;
            SEG_E: r = (dig == n - 1) ? 2 * n + 2 : -1;
            SEG_F: r = (dig == n - 1) ? 2 * n + 3 : -1;
            default: r = -1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_disp_ctrl_if.sv
// Switch/pin bundle for seq_disp_ctrl.
// master: drives en/dir/speed/mode, receives an/seg/pos. slave: the controller.
// N_DIG must match the controller's N_DIG.
interface seq_disp_ctrl_if
    import seq_disp_pkg::*;
#(
    parameter int unsigned N_DIG = 4
);
    localparam int unsigned POS_W = pos_w(N_DIG);

    logic             en;
    logic             dir;
    logic [1:0]       speed;
    logic             mode;
    logic [N_DIG-1:0] an;
    logic [7:0]       seg;
    logic [POS_W-1:0] pos;

    modport master (output en, dir, speed, mode, input an, seg, pos);
    modport slave  (input en, dir, speed, mode, output an, seg, pos);
endinterface

// File: rtl/tick_div.sv
// Programmable-divisor counter: counts 0..div-1 while run=1 and flags the
// terminal count for one cycle. run=0 or clr=1 returns the count to 0.
// Ports: clk, reset (async active-low), run, clr, div, tick_c (combinational).
module tick_div #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         run,
    input  logic         clr,
    input  logic [W-1:0] div,
    output logic         tick_c
);
    logic [W-1:0] cnt_q, cnt_d;
    logic         armed_q, armed_d;
    logic [W-1:0] term_c;

    // armed_q remembers run from the previous cycle so a tick at terminal
    // count still fires in the cycle run drops, but never while idle.
    assign term_c  = div - W'(1);
    assign tick_c  = armed_q && (cnt_q >= term_c);
    assign armed_d = run;

    // >= tolerates a divisor that shrinks below the current count
    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (!run || clr || tick_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end
endmodule

// File: rtl/seq_disp_ctrl.sv
// Sequential-lights controller for an N_DIG common-anode 7-segment display.
// Runs a lit pattern around the display perimeter and scans the digits.
// Ports: clk, reset (async active-low), bus (seq_disp_ctrl_if.slave):
//   en/dir/speed/mode in, an (active-low digit enable), seg {dp,g..a}
//   active-low, pos (pattern counter) out.
// Build option: define SEQ_DISP_FILL_EN to add the fill mode.
module seq_disp_ctrl
    import seq_disp_pkg::*;
#(
    parameter int unsigned N_DIG    = 4,
    parameter int unsigned STEP_DIV = 50_000_000,
    parameter int unsigned SCAN_DIV = 100_000
) (
    input  logic           clk,
    input  logic           reset,
    seq_disp_ctrl_if.slave bus
);
    localparam int unsigned P       = 2 * N_DIG + 4;
    localparam int unsigned POS_W   = pos_w(N_DIG);
    localparam int unsigned SCAN_W  = $clog2(N_DIG);
    localparam int unsigned STEP_CW = $clog2(STEP_DIV + 1);
    localparam int unsigned SCAN_CW = $clog2(SCAN_DIV + 1);

    logic [POS_W-1:0]   pos_q, pos_d;
    logic [SCAN_W-1:0]  scan_idx_q, scan_idx_d;
    logic [N_DIG-1:0]   an_q, an_d;
    logic [7:0]         seg_q, seg_d;
    logic [STEP_CW-1:0] step_div_c;
    logic               step_tick_c, scan_tick_c;
    logic               mode_clr_c, fill_c;
    dir_e               dir_c;

    assign dir_c      = dir_e'(bus.dir);
    assign step_div_c = STEP_CW'(STEP_DIV >> bus.speed);

`ifdef SEQ_DISP_FILL_EN
    mode_e mode_q, mode_d;

    assign mode_d     = mode_e'(bus.mode);
    assign mode_clr_c = (mode_d != mode_q);
    assign fill_c     = (mode_q == FILL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mode_q <= CHASE;
        else        mode_q <= mode_d;
    end
`else
    logic unused_mode;

    assign unused_mode = bus.mode;
    assign mode_clr_c  = 1'b0;
    assign fill_c      = 1'b0;
`endif

    tick_div #(.W(STEP_CW)) u_step_div (
        .clk    (clk),
        .reset  (reset),
        .run    (bus.en),
        .clr    (mode_clr_c),
        .div    (step_div_c),
        .tick_c (step_tick_c)
    );

    tick_div #(.W(SCAN_CW)) u_scan_div (
        .clk    (clk),
        .reset  (reset),
        .run    (1'b1),
        .clr    (1'b0),
        .div    (SCAN_CW'(SCAN_DIV)),
        .tick_c (scan_tick_c)
    );

    // Is perimeter position k lit for the current pattern state
    function automatic logic is_lit(input int k, input logic [POS_W-1:0] p,
                                    input logic fill, input dir_e d);
        if (k < 0)     return 1'b0;
        if (!fill)     return (k == int'(p));
        if (d == CW)   return (k < int'(p));
        return (k >= int'(P) - int'(p));
    endfunction

    // Pattern step, digit scan and registered pin values
    always_comb begin
        pos_d      = pos_q;
        scan_idx_d = scan_idx_q;
        an_d       = ~(N_DIG'(1) << scan_idx_q);
        seg_d      = 8'hFF;

        if (mode_clr_c) begin
            pos_d = '0;
        end else if (step_tick_c) begin
            if (fill_c) begin
                pos_d = (pos_q == POS_W'(P)) ? '0 : pos_q + POS_W'(1);
            end else if (dir_c == CW) begin
                pos_d = (pos_q == POS_W'(P - 1)) ? '0 : pos_q + POS_W'(1);
            end else begin
                pos_d = (pos_q == '0) ? POS_W'(P - 1) : pos_q - POS_W'(1);
            end
        end

        if (scan_tick_c) begin
            scan_idx_d = (scan_idx_q == SCAN_W'(N_DIG - 1)) ? '0 : scan_idx_q + SCAN_W'(1);
        end

        for (int s = SEG_A; s <= SEG_G; s++) begin
            if (is_lit(perim_idx(int'(scan_idx_q), s, int'(N_DIG)), pos_q, fill_c, dir_c)) begin
                seg_d[s] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_q      <= '0;
            scan_idx_q <= '0;
            an_q       <= '1;
            seg_q      <= 8'hFF;
        end else begin
            pos_q      <= pos_d;
            scan_idx_q <= scan_idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.pos = pos_q;
endmodule

// File: tb/tb_seq_disp_ctrl.sv
// Directed bench for seq_disp_ctrl with N_DIG=4, STEP_DIV=8, SCAN_DIV=2.
// Expectations switch with SEQ_DISP_FILL_EN for the fill section.
module tb_seq_disp_ctrl;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    seq_disp_ctrl_if #(.N_DIG(4)) bus ();

    seq_disp_ctrl #(
        .N_DIG    (4),
        .STEP_DIV (8),
        .SCAN_DIV (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for digit d to be driven, then check its segments
    task automatic check_digit(input int d, input logic [7:0] exp, input string tag);
        logic [3:0] want_an;
        bit         found;
        want_an = ~(4'b0001 << d);
        found   = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            if (bus.an === want_an) found = 1'b1;
            else                    clocks(1);
        end
        chk({tag, "_an"}, 32'(bus.an), 32'(want_an));
        chk(tag, 32'(bus.seg), 32'(exp));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.en    = 1'b0;
        bus.dir   = 1'b0;
        bus.speed = 2'd0;
        bus.mode  = 1'b0;

        // reset state
        clocks(3);
        chk("rst_an", 32'(bus.an), 32'h0000_000F);
        chk("rst_seg", 32'(bus.seg), 32'h0000_00FF);
        chk("rst_pos", 32'(bus.pos), 32'd0);
        reset = 1'b1;
        clocks(1);
        chk("rel_an", 32'(bus.an), 32'h0000_000E);
        chk("rel_seg", 32'(bus.seg), 32'h0000_00FF);

        // clockwise chase over a full revolution
        bus.en = 1'b1;
        clocks(7);
        chk("cw_first_hold", 32'(bus.pos), 32'd0);
        clocks(1);
        chk("cw_first_step", 32'(bus.pos), 32'd1);
        for (int i = 2; i <= 12; i++) begin
            clocks(8);
            chk($sformatf("cw_step%0d", i), 32'(bus.pos), 32'(i % 12));
        end

        // freeze at pos 0 and look at the digits
        bus.en = 1'b0;
        clocks(2);
        check_digit(3, 8'hFE, "cw0_d3");
        check_digit(0, 8'hFF, "cw0_d0");
        check_digit(1, 8'hFF, "cw0_d1");
        check_digit(2, 8'hFF, "cw0_d2");
        chk("cw0_frozen", 32'(bus.pos), 32'd0);

        // counter-clockwise wrap 0 -> 11
        bus.dir = 1'b1;
        bus.en  = 1'b1;
        clocks(7);
        chk("ccw_hold", 32'(bus.pos), 32'd0);
        clocks(1);
        chk("ccw_wrap", 32'(bus.pos), 32'd11);
        bus.en = 1'b0;
        clocks(1);
        check_digit(3, 8'hDF, "ccw11_d3");
        check_digit(0, 8'hFF, "ccw11_d0");

        // run cw to 3, freeze, resume
        bus.dir = 1'b0;
        bus.en  = 1'b1;
        clocks(32);
        chk("to3", 32'(bus.pos), 32'd3);
        bus.en = 1'b0;
        clocks(20);
        chk("freeze3", 32'(bus.pos), 32'd3);
        check_digit(0, 8'hFE, "frz3_d0");
        check_digit(1, 8'hFF, "frz3_d1");
        bus.en = 1'b1;
        clocks(7);
        chk("resume_hold", 32'(bus.pos), 32'd3);
        clocks(1);
        chk("resume_step", 32'(bus.pos), 32'd4);

        // speed 2: step every 2 clocks
        bus.speed = 2'd2;
        clocks(1);
        chk("spd2_a", 32'(bus.pos), 32'd4);
        clocks(1);
        chk("spd2_b", 32'(bus.pos), 32'd5);
        clocks(1);
        chk("spd2_c", 32'(bus.pos), 32'd5);
        clocks(1);
        chk("spd2_d", 32'(bus.pos), 32'd6);
        bus.en    = 1'b0;
        bus.speed = 2'd0;
        clocks(2);

        // fill mode (chase when the option is not built)
        bus.mode = 1'b1;
        clocks(1);
`ifdef SEQ_DISP_FILL_EN
        chk("mode_clr", 32'(bus.pos), 32'd0);
`else
        chk("mode_clr", 32'(bus.pos), 32'd6);
`endif
        clocks(1);
        bus.en = 1'b1;
        clocks(40);
        bus.en = 1'b0;
        clocks(1);
`ifdef SEQ_DISP_FILL_EN
        chk("fill5_pos", 32'(bus.pos), 32'd5);
        check_digit(0, 8'hFC, "fill5_d0");
        check_digit(1, 8'hFE, "fill5_d1");
        check_digit(3, 8'hFE, "fill5_d3");
`else
        chk("fill5_pos", 32'(bus.pos), 32'd11);
        check_digit(0, 8'hFF, "fill5_d0");
        check_digit(1, 8'hFF, "fill5_d1");
        check_digit(3, 8'hDF, "fill5_d3");
`endif
        bus.en = 1'b1;
        clocks(64);
        bus.en = 1'b0;
        clocks(1);
`ifdef SEQ_DISP_FILL_EN
        chk("fill13_pos", 32'(bus.pos), 32'd0);
        check_digit(0, 8'hFF, "fill13_d0");
        check_digit(1, 8'hFF, "fill13_d1");
`else
        chk("fill13_pos", 32'(bus.pos), 32'd7);
        check_digit(0, 8'hFF, "fill13_d0");
        check_digit(1, 8'hF7, "fill13_d1");
`endif

        // back to chase, run, then async reset between edges
        bus.mode = 1'b0;
        clocks(2);
`ifdef SEQ_DISP_FILL_EN
        chk("chase_back", 32'(bus.pos), 32'd0);
`else
        chk("chase_back", 32'(bus.pos), 32'd7);
`endif
        bus.en = 1'b1;
        clocks(20);
`ifdef SEQ_DISP_FILL_EN
        chk("prerst_pos", 32'(bus.pos), 32'd2);
`else
        chk("prerst_pos", 32'(bus.pos), 32'd9);
`endif
        #3;
        reset = 1'b0;
        #1;
        chk("arst_an", 32'(bus.an), 32'h0000_000F);
        chk("arst_seg", 32'(bus.seg), 32'h0000_00FF);
        chk("arst_pos", 32'(bus.pos), 32'd0);
        clocks(1);
        chk("arst_hold_pos", 32'(bus.pos), 32'd0);
        bus.en = 1'b0;
        reset  = 1'b1;
        clocks(1);
        chk("arst_rel_an", 32'(bus.an), 32'h0000_000E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
